// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sharing of a single sync-read data RAM between the
// core load/store port (CORE) and the debug/program-loader port (DBG). One access
// is issued per cycle. Read returns are tracked through a short pipe that mirrors
// the RAM read latency, so each returning word is steered to the requester that
// issued it.
module dmem_arbiter #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              core_req,
   input  logic              core_we,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic [DATA_W-1:0] core_wdata,
   output logic              core_gnt,
   output logic              core_stall,
   output logic              core_rvalid,
   output logic [DATA_W-1:0] core_rdata,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic              dbg_gnt,
   output logic              dbg_rvalid,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_data,
   output logic              mem_rden,
   output logic              mem_wren,
   input  logic [DATA_W-1:0] mem_q
);

   // Requester identities, used both for the last-grant register and the return-pipe id.
   localparam logic [0:0] GNT_CORE = 1'b0;
   localparam logic [0:0] GNT_DBG  = 1'b1;

   logic [0:0]        lastGnt_q;
   logic [0:0]        lastGnt_d;
   logic [RD_LAT-1:0] validPipe_q;
   logic [RD_LAT-1:0] validPipe_d;
   logic [RD_LAT-1:0] idPipe_q;
   logic [RD_LAT-1:0] idPipe_d;
   logic              coreGnt;
   logic              dbgGnt;

   // Round-robin grant: a lone requester wins outright, on contention the one not
   // granted last time wins. Nothing is granted while reset is held.
   always_comb begin
      coreGnt = 1'b0;
      dbgGnt  = 1'b0;
      if (!rst) begin
         if (core_req && (!dbg_req || lastGnt_q == GNT_DBG)) begin
            coreGnt = 1'b1;
         end else if (dbg_req) begin
            dbgGnt = 1'b1;
         end
      end
   end

   assign core_gnt   = coreGnt;
   assign dbg_gnt    = dbgGnt;
   assign core_stall = core_req & ~coreGnt;

   // Issue mux: the granted requester drives the RAM; idle cycles drive all zeros
   // so the RAM sees no enables and a quiet address/data bus.
   always_comb begin
      mem_address = '0;
      mem_data    = '0;
      mem_rden    = 1'b0;
      mem_wren    = 1'b0;
      if (coreGnt) begin
         mem_address = core_addr;
         mem_data    = core_wdata;
         mem_wren    = core_we;
         mem_rden    = ~core_we;
      end else if (dbgGnt) begin
         mem_address = dbg_addr;
         mem_data    = dbg_wdata;
         mem_wren    = dbg_we;
         mem_rden    = ~dbg_we;
      end
   end

   // Next-state for the last-grant register and the read-return pipe. A granted read
   // enters stage 0 and emerges at stage RD_LAT-1 in the same cycle mem_q is valid.
   always_comb begin
      lastGnt_d = lastGnt_q;
      if (coreGnt) begin
         lastGnt_d = GNT_CORE;
      end else if (dbgGnt) begin
         lastGnt_d = GNT_DBG;
      end
      validPipe_d    = validPipe_q;
      idPipe_d       = idPipe_q;
      validPipe_d[0] = mem_rden;
      idPipe_d[0]    = dbgGnt;
      for (int i = 1; i < RD_LAT; i++) begin
         validPipe_d[i] = validPipe_q[i-1];
         idPipe_d[i]    = idPipe_q[i-1];
      end
   end

   // State update; reset drops any reads still in flight and lets CORE win first contention.
   always_ff @(posedge clk) begin
      if (rst) begin
         lastGnt_q   <= GNT_DBG;
         validPipe_q <= '0;
         idPipe_q    <= '0;
      end else begin
         lastGnt_q   <= lastGnt_d;
         validPipe_q <= validPipe_d;
         idPipe_q    <= idPipe_d;
      end
   end

   assign core_rvalid = validPipe_q[RD_LAT-1] & (idPipe_q[RD_LAT-1] == GNT_CORE);
   assign dbg_rvalid  = validPipe_q[RD_LAT-1] & (idPipe_q[RD_LAT-1] == GNT_DBG);
   assign core_rdata  = mem_q;
   assign dbg_rdata   = mem_q;

endmodule
